// File: rtl/lut_poly_song_player_if.sv
// Control, table-write and status bundle for the polyphonic song player.
// The sequencer is the slave; whoever drives start/stop and the table is the master.
interface lut_poly_song_player_if #(
    parameter int CHANNELS = 2,
    parameter int HALF_W   = 15,
    parameter int DUR_W    = 8,
    parameter int ADDR_W   = 7
);
    localparam int ENTRY_W = 1 + CHANNELS*HALF_W + DUR_W;
    localparam int MIX_W   = $clog2(CHANNELS+1);

    logic                start;
    logic                stop;
    logic                loop_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ENTRY_W-1:0]  wr_data;
    logic [CHANNELS-1:0] speaker;
    logic [MIX_W-1:0]    mix;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   note_index;

    modport master (
        output start, stop, loop_en, wr_en, wr_addr, wr_data,
        input  speaker, mix, busy, done, note_index
    );
    modport slave (
        input  start, stop, loop_en, wr_en, wr_addr, wr_data,
        output speaker, mix, busy, done, note_index
    );
endinterface

// File: rtl/lut_poly_song_player.sv
// Table-driven sequencer feeding CHANNELS square-wave tone generators.
// Each entry: {end, ch[CHANNELS-1..0] half-periods, duration in beat ticks}.
module lut_poly_song_player #(
    parameter int CHANNELS = 2,
    parameter int HALF_W   = 15,
    parameter int DUR_W    = 8,
    parameter int ADDR_W   = 7,
    parameter int TICK_DIV = 20910
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lut_poly_song_player_if.slave   bus
);
    localparam int ENTRY_W = 1 + CHANNELS*HALF_W + DUR_W;
    localparam int MIX_W   = $clog2(CHANNELS+1);
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

    state_t                         r_state, w_nxt;
    logic [ENTRY_W-1:0]             r_mem [2**ADDR_W];
    logic [ENTRY_W-1:0]             r_rd;
    logic [ADDR_W-1:0]              r_idx, w_nxt_idx;
    logic                           r_done, w_done, w_latch;
    logic [TICK_W-1:0]              r_tick;
    logic [DUR_W-1:0]               r_rem;
    logic [CHANNELS-1:0][HALF_W-1:0] r_half, r_cnt;
    logic [CHANNELS-1:0]            r_spk;
    logic [MIX_W-1:0]               r_mix;
    logic                           w_end, w_wrap, w_play;
    logic [DUR_W-1:0]               w_dur;

    function automatic logic [MIX_W-1:0] f_pop(input logic [CHANNELS-1:0] v);
        f_pop = '0;
        for (int i = 0; i < CHANNELS; i++) f_pop = f_pop + MIX_W'(v[i]);
    endfunction

    assign w_end  = r_rd[ENTRY_W-1];
    assign w_dur  = r_rd[DUR_W-1:0];
    assign w_wrap = (r_tick == TICK_W'(TICK_DIV-1));
    // Tones only run while PLAY continues; entering or leaving PLAY silences them.
    assign w_play = (r_state == S_PLAY) && (w_nxt == S_PLAY);

    always_comb begin
        w_nxt     = r_state;
        w_nxt_idx = r_idx;
        w_done    = 1'b0;
        w_latch   = 1'b0;
        if (bus.stop) begin
            w_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (bus.start) begin
                    w_nxt     = S_LOAD;
                    w_nxt_idx = '0;
                end
                S_LOAD: if (!w_end) begin
                    w_nxt   = S_PLAY;
                    w_latch = 1'b1;
                end else if (bus.loop_en && r_idx != '0) begin
                    w_nxt_idx = '0;
                end else begin
                    // End at address 0 always terminates so an empty song cannot spin.
                    w_nxt  = S_IDLE;
                    w_done = 1'b1;
                end
                S_PLAY: if (w_wrap && r_rem <= DUR_W'(1)) begin
                    w_nxt     = S_LOAD;
                    w_nxt_idx = r_idx + 1'b1;
                end
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    // Read address is the next note_index, so LOAD sees its entry after one cycle.
    always_ff @(posedge clk) begin
        if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
        r_rd <= r_mem[w_nxt_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_tick  <= '0;
            r_rem   <= '0;
            r_half  <= '0;
            r_mix   <= '0;
        end else begin
            r_state <= w_nxt;
            r_idx   <= w_nxt_idx;
            r_done  <= w_done;
            r_mix   <= f_pop(r_spk);
            if (w_latch) begin
                r_tick <= '0;
                r_rem  <= (w_dur == '0) ? DUR_W'(1) : w_dur;
                for (int c = 0; c < CHANNELS; c++)
                    r_half[c] <= r_rd[DUR_W + c*HALF_W +: HALF_W];
            end else if (r_state == S_PLAY) begin
                r_tick <= w_wrap ? '0 : r_tick + 1'b1;
                if (w_wrap) r_rem <= r_rem - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_spk <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!w_play || r_half[c] == '0) begin
                    r_cnt[c] <= '0;
                    r_spk[c] <= 1'b0;
                end else if (r_cnt[c] == r_half[c]) begin
                    r_cnt[c] <= '0;
                    r_spk[c] <= ~r_spk[c];
                end else begin
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    assign bus.speaker    = r_spk;
    assign bus.mix        = r_mix;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;
    assign bus.note_index = r_idx;
endmodule

// File: tb/tb_lut_poly_song_player.sv
// Scoreboard bench: a song-level model expands the table into per-cycle expected
// outputs; a negedge monitor pops and compares them against the player.
module tb_lut_poly_song_player;
    localparam int CH = 2, HW = 4, DW = 4, AW = 3, TD = 4;
    localparam int EW = 1 + CH*HW + DW;
    localparam int MW = $clog2(CH+1);
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [CH-1:0] spk;
        logic [MW-1:0] mix;
        logic          busy;
        logic          done;
        logic [AW-1:0] idx;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_poly_song_player_if #(.CHANNELS(CH), .HALF_W(HW), .DUR_W(DW), .ADDR_W(AW)) bus();

    lut_poly_song_player #(.CHANNELS(CH), .HALF_W(HW), .DUR_W(DW), .ADDR_W(AW), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rec_t           expq[$];
    rec_t           seq[$];
    logic [EW-1:0]  tbl [DEPTH];
    int             errors = 0;
    int             checks = 0;
    int             exp_idx = 0;
    int             mon_n = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        rec_t e, a;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            a.spk = bus.speaker; a.mix = bus.mix; a.busy = bus.busy;
            a.done = bus.done; a.idx = bus.note_index;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL rec%0d spk=%b/%b mix=%0d/%0d busy=%b/%b done=%b/%b idx=%0d/%0d (actual/expected)",
                         mon_n, a.spk, e.spk, a.mix, e.mix, a.busy, e.busy, a.done, e.done, a.idx, e.idx);
            end
            mon_n++;
        end
    end

    function automatic logic [EW-1:0] ent(input bit e, input int p0, input int p1, input int dur);
        logic [EW-1:0] v;
        v = '0;
        v[EW-1]     = e;
        v[DW +: HW] = p0[HW-1:0];
        v[DW+HW +: HW] = p1[HW-1:0];
        v[DW-1:0]   = dur[DW-1:0];
        return v;
    endfunction

    task automatic wr(input int a, input logic [EW-1:0] d);
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.wr_addr = a[AW-1:0]; bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic load_tbl();
        for (int a = 0; a < DEPTH; a++) wr(a, tbl[a]);
    endtask

    // Song-level model: notes of max(dur,1)*TD cycles, one LOAD cycle each,
    // channel c high during the odd (P+1)-cycle halves of a note.
    task automatic gen(input bit lp, input int max_n, output int stop_at);
        int a, d, p;
        bit fin;
        logic [EW-1:0] e;
        rec_t r;
        seq.delete();
        a = 0; fin = 0;
        r = '0; r.idx = exp_idx[AW-1:0];
        seq.push_back(r);
        while (!fin && seq.size() < max_n) begin
            e = tbl[a];
            r = '0; r.busy = 1'b1; r.idx = a[AW-1:0];
            seq.push_back(r);
            if (!e[EW-1]) begin
                d = ((e[DW-1:0] == '0) ? 1 : int'(e[DW-1:0])) * TD;
                for (int t = 0; t < d; t++) begin
                    for (int c = 0; c < CH; c++) begin
                        p = int'(e[DW + c*HW +: HW]);
                        r.spk[c] = (p != 0) && (((t / (p+1)) % 2) == 1);
                    end
                    seq.push_back(r);
                end
                a = (a + 1) % DEPTH;
            end else if (lp && a != 0) begin
                a = 0;
            end else begin
                r = '0; r.done = 1'b1; r.idx = a[AW-1:0];
                seq.push_back(r);
                fin = 1;
            end
        end
        if (fin && seq.size() <= max_n) begin
            stop_at = -1;
            exp_idx = a;
        end else begin
            while (seq.size() > max_n) void'(seq.pop_back());
            stop_at = max_n - 1;
            exp_idx = int'(seq[max_n-1].idx);
        end
        for (int i = 0; i < 2; i++) begin
            r = '0; r.idx = exp_idx[AW-1:0];
            seq.push_back(r);
        end
        for (int i = seq.size()-1; i >= 1; i--)
            seq[i].mix = MW'($countones(seq[i-1].spk));
    endtask

    task automatic drain(input int lim);
        int k;
        k = 0;
        while (expq.size() > 0 && k < lim) begin
            @(posedge clk); #1; k++;
        end
        if (expq.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout left=%0d expected=0", expq.size());
            expq.delete();
        end
    endtask

    // Start a song; re-pulse start during the first LOAD (must be ignored);
    // optionally stop after max_n cycles and write wr_d to wr_a while wr_a-1 plays.
    task automatic run_song(input bit lp, input int max_n, input int wr_a, input logic [EW-1:0] wr_d);
        int stop_at, wr_at, k, lim;
        gen(lp, max_n, stop_at);
        wr_at = -1;
        if (wr_a > 0)
            for (int i = 0; i < seq.size(); i++)
                if (wr_at < 0 && seq[i].busy && int'(seq[i].idx) == wr_a-1) wr_at = i + 1;
        @(posedge clk); #1;
        foreach (seq[i]) expq.push_back(seq[i]);
        bus.loop_en = lp;
        bus.start = 1'b1;
        k = 0; lim = seq.size() + 20;
        while (expq.size() > 0 && k < lim) begin
            @(posedge clk); #1; k++;
            bus.start = (k == 1);
            bus.stop  = (k == stop_at);
            bus.wr_en = (k == wr_at);
            if (k == wr_at) begin
                bus.wr_addr = wr_a[AW-1:0];
                bus.wr_data = wr_d;
            end
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.wr_en = 1'b0;
        drain(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rec_t r;
        int p0, p1, len, lp, mx;
        bus.start = 0; bus.stop = 0; bus.loop_en = 0; bus.wr_en = 0;
        bus.wr_addr = '0; bus.wr_data = '0;
        #2;
        chk("rst_speaker", int'(bus.speaker), 0);
        chk("rst_mix", int'(bus.mix), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_idx", int'(bus.note_index), 0);
        @(negedge clk); rst_n = 1'b1;

        // one-shot: ch0 period 6, ch1 silent, 8-cycle note, done 10 cycles after LOAD
        for (int a = 0; a < DEPTH; a++) tbl[a] = ent(1, 0, 0, 0);
        tbl[0] = ent(0, 2, 0, 2);
        load_tbl();
        run_song(0, 200, -1, '0);

        // two tones with mix
        tbl[0] = ent(0, 1, 3, 3);
        tbl[1] = ent(0, 3, 2, 1);
        load_tbl();
        run_song(0, 200, -1, '0);

        // loop with a dur=0 note, stopped after a few laps
        tbl[0] = ent(0, 2, 1, 0);
        tbl[1] = ent(0, 3, 0, 1);
        tbl[2] = ent(1, 0, 0, 0);
        load_tbl();
        run_song(1, 40, -1, '0);

        // stop together with start in IDLE stays idle
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            r = '0; r.idx = exp_idx[AW-1:0];
            expq.push_back(r);
        end
        bus.start = 1'b1; bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0;
        drain(10);

        // stop mid-PLAY
        tbl[0] = ent(0, 1, 2, 3);
        load_tbl();
        run_song(0, 7, -1, '0);

        // wrap 7->0 with a table write to entry 3 while entry 2 plays
        for (int a = 0; a < DEPTH; a++) tbl[a] = ent(0, a + 1, 7 - a, 0);
        load_tbl();
        tbl[3] = ent(0, 5, 4, 2);
        run_song(0, 60, 3, tbl[3]);

        // async reset mid-PLAY of note 1
        tbl[0] = ent(0, 1, 2, 1);
        tbl[1] = ent(0, 3, 1, 2);
        tbl[2] = ent(1, 0, 0, 0);
        load_tbl();
        @(posedge clk); #1; bus.loop_en = 0; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        chk("pre_rst_idx", int'(bus.note_index), 1);
        chk("pre_rst_spk", int'(bus.speaker), 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_speaker", int'(bus.speaker), 0);
        chk("async_rst_mix", int'(bus.mix), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_done", int'(bus.done), 0);
        chk("async_rst_idx", int'(bus.note_index), 0);
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", int'(bus.busy), 0);
        chk("post_rst_speaker", int'(bus.speaker), 0);
        exp_idx = 0;

        // randomized songs
        for (int n = 0; n < 30; n++) begin
            len = $urandom_range(4, 0);
            for (int a = 0; a < DEPTH; a++) begin
                p0 = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(15, 1);
                p1 = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(15, 1);
                if (a == len)     tbl[a] = ent(1, p0, p1, $urandom_range(15, 0));
                else if (a < len) tbl[a] = ent(0, p0, p1, $urandom_range(3, 0));
                else              tbl[a] = ent($urandom_range(1, 0), p0, p1, $urandom_range(3, 0));
            end
            load_tbl();
            lp = $urandom_range(1, 0);
            mx = (lp != 0 || $urandom_range(3, 0) == 0) ? $urandom_range(80, 3) : 200;
            run_song(lp[0], mx, -1, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lut_poly_song_player.md
Name: lut_poly_song_player

Overview:
- Multi-channel successor to the single-tone LUT song player: a sequencer that steps through an internal song table and drives CHANNELS independent square-wave tone generators.
- Each table entry carries per-channel half-periods (0 = rest), a per-note duration in beat ticks, and an end-of-song flag.
- Adds start/stop control, one-shot or loop mode, a runtime table write port, and busy/done status.
- Sits between the board clock and the speaker pins and replaces the fixed-tempo, fixed-file player.

Parameters:
- CHANNELS, 2, number of simultaneous tone channels (1..8).
- HALF_W, 15, width of each channel half-period field.
- DUR_W, 8, width of the duration field, in beat ticks.
- ADDR_W, 7, song table address width; depth is 2^ADDR_W.
- TICK_DIV, 20910, clk cycles per beat tick.
- ENTRY_W, 1+CHANNELS*HALF_W+DUR_W, derived entry width; never overridden.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; starts playback from address 0 when idle.
- stop  in  1  single-cycle pulse; aborts playback.
- loop_en  in  1  sampled when the end flag is read: 1 = restart at 0, 0 = finish.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write address.
- wr_data  in  ENTRY_W  entry. Bit [ENTRY_W-1] = end flag; next CHANNELS*HALF_W bits hold channel c at [DUR_W+(c+1)*HALF_W-1 : DUR_W+c*HALF_W]; [DUR_W-1:0] = duration.
- speaker  out  CHANNELS  per-channel square wave.
- mix  out  $clog2(CHANNELS+1)  count of speaker bits currently high, registered.
- busy  out  1  high in LOAD or PLAY.
- done  out  1  one-cycle pulse on normal end of a one-shot song.
- note_index  out  ADDR_W  address of the entry currently loading or playing.

Behaviour:
- Reset with rst_n low, asynchronously: state IDLE, speaker=0, mix=0, busy=0, done=0, note_index=0, all counters 0. Table contents are not reset.
- Table: synchronous write; synchronous read with 1-cycle latency. A same-cycle write and read of one address returns the old data. Writes are legal in any state.
- IDLE: speaker=0. When start=1 and stop=0 -> LOAD, with note_index=0 and busy=1 on the next cycle. start while busy is ignored.
- LOAD, exactly 1 cycle:
  - entry[note_index] is read.
  - If end=0: latch the half-periods and duration, clear the tick and tone counters, clear speaker -> PLAY.
  - If end=1 and (loop_en=1 and note_index!=0): note_index=0, stay in LOAD.
  - Otherwise (end=1): -> IDLE and pulse done. An end flag at address 0 always terminates, so an empty song cannot hang.
- PLAY lasts max(dur,1)*TICK_DIV cycles. The tick counter runs 0..TICK_DIV-1; at each wrap the remaining-duration counter decrements. When it reaches 0: note_index+1 (wraps 2^ADDR_W-1 -> 0) -> LOAD. Total per note = max(dur,1)*TICK_DIV + 1 cycles.
- Tone channel c with latched half-period P:
  - P!=0: the counter counts 0..P; at P it clears and speaker[c] toggles. Half period is P+1 cycles; the first toggle comes P+1 cycles after PLAY entry.
  - P=0: rest; speaker[c]=0 and the counter is held at 0.
- mix = popcount(speaker), registered, so it lags speaker by 1 cycle.
- stop=1 in any state: the next cycle is IDLE with speaker=0, busy=0, no done pulse, and note_index held. stop has priority over start in the same cycle.
- done is high for exactly 1 cycle; busy falls in the same cycle done rises.

Test Plan (CHANNELS=2, HALF_W=4, DUR_W=4, ADDR_W=3, TICK_DIV=4):
- Reset mid-PLAY: drop rst_n -> all outputs 0 in the same cycle without a clk edge; after release, state is IDLE.
- One-shot: entry0 = {end 0, ch0 P=2, ch1 P=0, dur=2}, entry1 = end -> ch0 toggles every 3 cycles and ch1 stays 0. PLAY lasts 8 cycles, then LOAD of entry1. done pulses 10 cycles after the first LOAD (1 + 8 + 1), and busy=0 on the same cycle.
- Two-tone and mix: ch0 P=1, ch1 P=3, dur=3 -> ch0 has period 4 and ch1 period 8. mix follows popcount one cycle late, with values in 0..2.
- Loop: entries 0,1 playing, entry 2 = end, loop_en=1 -> note_index sequence 0,1,2,0,1,... with no done; dur=0 behaves exactly as dur=1.
- Stop and contention: stop together with start in IDLE -> stays IDLE. stop mid-PLAY -> next cycle speaker=0, busy=0, done=0. start while busy -> no effect on note_index.
- Wrap and write: fill all 8 entries with end=0 and loop_en=0 -> note_index wraps 7->0 and playback continues. A write to entry 3 while entry 2 plays -> the new value is heard at note 3.
